// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration on the request side. Each accepted operation
// occupies the ALU for a single execute cycle. The registered result is
// returned on one response channel, tagged with the owning requester id.
module alu_share_arbiter #(
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_c,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NONE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             prio;       // requester that wins when both are valid
  logic             grant;      // selected requester id
  logic             grant_vld;  // at least one requester is pending
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;

  // True for the five op codes the ALU understands.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NONE: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Illegal codes are replaced by NONE so the ALU never sees them.
  function automatic logic [3:0] op_sanitize(input logic [3:0] op);
    return op_legal(op) ? op : OP_NONE;
  endfunction

  // Arbitration: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Winner's operands, muxed ahead of the accept edge.
  always_comb begin
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
  end

  // Ready is only offered in IDLE to the granted, pending requester, and
  // is held low while reset is asserted.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && grant_vld && !grant;
    req1_ready = rst_n && (state == IDLE) && grant_vld &&  grant;
  end

  // Control FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= OP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            // Accept edge: the ALU drive registers double as the operand latch.
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= op_sanitize(sel_op);
            rsp_err  <= ~op_legal(sel_op);
            rsp_id   <= grant;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Capture the ALU result and return the ALU inputs to idle values.
          rsp_data  <= alu_c;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_ctrl  <= OP_NONE;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            // Hand priority to the requester that was not just served.
            prio      <= ~rsp_id;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, port 0 and port 1. It uses round-robin arbitration with valid/ready handshakes.
- The block captures the winner's operands and drives the ALU operand and control inputs for one execute cycle. It registers the ALU result and returns it on a common response channel tagged with the requester id.
- It sits between the CPU front-end requesters and the ALU instance.

Parameters:
- WIDTH, 62, operand and result width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  4  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as the requester 0 signals, for requester 1.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_ctrl  out  4  ALU control.
- alu_c  in  WIDTH  ALU result, combinational from alu_a, alu_b and alu_ctrl.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  registered ALU result.
- rsp_err  out  1  the op code was illegal.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Op codes:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, NONE=0111.
  - Any other code is illegal. An illegal code is forwarded to the ALU as NONE and rsp_err=1 is set for that transaction.
- States are IDLE, EXEC and RESP.
- IDLE:
  - If exactly one reqX_valid is high, grant that requester.
  - If both are high, grant the holder of the priority pointer.
  - reqX_ready is combinational and equals (state==IDLE && grant==X). It is never high for both requesters at once.
  - On the accept edge:
    - latch a, b, the sanitised op, the err flag and the id;
    - go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC:
  - alu_a, alu_b and alu_ctrl are driven from the latched registers.
  - At the end of the cycle, rsp_data<=alu_c; then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - On an edge with rsp_ready=1:
    - go to IDLE;
    - set the priority pointer to the requester that did not own the response.
  - If rsp_ready=0, stay in RESP indefinitely. No new request is accepted in this state.
- ALU drive outside EXEC:
  - alu_a=0, alu_b=0, alu_ctrl=NONE.
  - In EXEC the latched values are driven.
- Latency and throughput:
  - If a request is accepted at edge T, rsp_valid rises after edge T+1. The response is visible in the cycle following EXEC, which is 2 cycles after acceptance.
  - Peak throughput is 1 operation per 3 cycles when rsp_ready is held high.
- Response handshake:
  - rsp_ready is ignored while rsp_valid=0.
  - rsp_ready asserted in the same cycle that rsp_valid first rises completes the transfer on that edge.
- Requester-side rules:
  - The block does not require reqX_valid to stay asserted after it is dropped before acceptance; such a request is simply never granted.
  - Operands are sampled only on the accept edge.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, priority pointer=0;
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0;
  - req0_ready and req1_ready low while rst_n=0;
  - ALU outputs at the idle values.
- Reset mid-operation discards the in-flight transaction; no response is produced.
- Arithmetic: no width manipulation. Results are exactly WIDTH bits as returned by the ALU, and SUB wrap-around is the ALU's behaviour, passed through unchanged.

Test Plan:
- Single request: req0 with a=2, b=1, op=ADD, rsp_ready=1. Required: req0_ready high in cycle 0; alu_ctrl=0010 in cycle 1; rsp_valid=1, rsp_id=0, rsp_data=3, rsp_err=0 in cycle 2; busy low by cycle 3.
- Contention and round-robin: req0 and req1 both held valid, with req0 {2,1,SUB}, req1 {2,1,OR}, and rsp_ready=1. Required:
  - grants alternate 0,1,0,1;
  - responses are id0 data 1, then id1 data 3;
  - acceptances occur every 3 cycles.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises. Required:
  - rsp_valid, rsp_data and rsp_id are stable throughout;
  - req0_ready and req1_ready stay 0 despite valid requests;
  - after rsp_ready=1, IDLE is entered and the other requester wins next.
- Illegal op: req1 with op=1111, a=5, b=3. Required: alu_ctrl=0111 during EXEC; rsp_err=1 and rsp_id=1.
- AND and all ops: req0 {6,3} issued with op AND, OR, ADD, SUB and NONE in turn. Required: rsp_data is 2, 7, 9 and 3 for the first four. For NONE, rsp_data equals the ALU model's NONE output, checked against the golden model.
- Asynchronous reset mid-EXEC: drop rst_n between edges while in EXEC. Required:
  - busy and rsp_valid go to 0 immediately, with no clock edge;
  - no response appears after release;
  - the next simultaneous request is granted to requester 0.
